mult_div_unit: RTL and testbench
================================

# mult_div_unit

Multi-cycle multiply/divide unit with HI/LO registers, sitting in the E stage beside the ALU. It accepts one mult/multu/div/divu per start pulse and holds Busy for a fixed latency. It commits the result to HI/LO at the end of that latency and produces the stall request the hazard unit uses to freeze the D stage. mthi/mtlo write HI/LO directly, and the exception path can cancel an in-flight operation.

## Interface
- MULT_CYCLES, 5, Busy cycles for mult/multu (≥2)
- DIV_CYCLES, 10, Busy cycles for div/divu (≥2)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- Start  in  1  E-stage instruction is an MDU op this cycle
- MDOp  in  3  operation code; meaning set by the MD_* constants in the shared defines
- A  in  32  operand rs, forwarded value
- B  in  32  operand rt, forwarded value
- Flush  in  1  exception/eret cancel of in-flight op
- MDUse  in  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo
- Busy  out  1  operation in flight
- Stall  out  1  freeze request to hazard unit
- HI  out  32  HI register
- LO  out  32  LO register

## Operation
- States: IDLE, RUN. Down-counter cnt is 4 bits; it must hold max(MULT_CYCLES, DIV_CYCLES).
- Reset:
  - State IDLE, cnt=0, HI=0, LO=0, Busy=0.
  - Pending result registers are cleared to 0.
- IDLE & Start & MDOp∈{MULT,MULTU}:
  - Compute 64-bit product: signed for MULT, zero-extended for MULTU.
  - Latch {hi,lo} into pending; cnt←MULT_CYCLES; go to RUN.
- IDLE & Start & MDOp∈{DIV,DIVU}:
  - Compute quotient→pending lo and remainder→pending hi.
  - Signed ops truncate toward zero; remainder sign follows A.
  - cnt←DIV_CYCLES; go to RUN.
  - B==0: still enters RUN for DIV_CYCLES. On completion HI/LO keep their prior values; pending is not committed.
  - DIV 0x80000000/−1: lo=0x80000000, hi=0.
- IDLE & Start & MTHI: HI←A at the clock edge. MTLO: LO←A. No Busy, no state change.
- Start with MDOp=NONE is a no-op.
- RUN:
  - cnt decrements each cycle.
  - When cnt==1: commit pending to HI/LO (unless a div-by-zero was flagged) and go to IDLE.
- Start while in RUN is ignored. The hazard unit guarantees this never happens.
- Flush in RUN: go to IDLE next edge, nothing committed, HI/LO unchanged.
- Flush in IDLE gates a same-cycle Start: no state change and no mthi/mtlo write.
- Flush and final cycle (cnt==1) together: Flush wins, no commit.
- reset has priority over everything.

## Timing
- Start sampled at edge E0. Busy=1 from the cycle after E0 for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES).
- HI/LO take the new value at the edge that ends the Nth Busy cycle. Busy=0 in the same cycle HI/LO first show the new value.
- Stall = MDUse & (Busy | (Start & MDOp∈{MULT,MULTU,DIV,DIVU})). Combinational, no register.
- HI/LO are registered outputs. mfhi/mflo read them directly; there is no bypass of pending.
- mthi/mtlo: value visible on HI/LO the cycle after Start.
- Back-to-back: a new Start is accepted in the first cycle with Busy=0.

## Structure
- Shared define header mdu_defs.vh holds:
  - MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6.
  - Default latency constants.
  - The decoder includes the same header.
- Single module; no sub-module. The arithmetic uses behavioural * / % on sign-extended 33-bit operands, computed once at Start. The counter only models latency.

## Test plan
- reset mid-RUN (div issued, reset at cnt=4) -> next cycle Busy=0, HI=LO=0, state IDLE.
- MULT A=0xFFFFFFFE(−2), B=3 -> Busy cycles 1–5. Cycle 6: HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV A=−7, B=2 -> after 10 Busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV A=5, B=0 with HI=LO=0x1234 -> both remain 0x1234 and Busy still lasts 10 cycles.
- MULT started, Flush at Busy cycle 3 -> Busy=0 next cycle, HI/LO unchanged. Flush coincident with cnt==1 -> no commit.
- MTLO A=0xDEADBEEF -> LO=0xDEADBEEF next cycle, Busy never asserts. Start with MDOp=MD_DIV during RUN -> ignored, original result committed.
- MDUse=1 with Start=MULT in the same cycle -> Stall=1 immediately, held through all Busy cycles, 0 in the first cycle Busy=0.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes, FSM
// states, default latencies and the arithmetic helpers evaluated at Start.
package mult_div_unit_pkg;

    // Operation codes carried on MDOp (shared with the decoder).
    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    // Default latencies in Busy cycles.
    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    // True for the ops that occupy the unit for a multi-cycle latency.
    function automatic logic is_long_op(input logic [2:0] op);
        logic res;
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: res = 1'b1;
            default:                            res = 1'b0;
        endcase
        return res;
    endfunction

    // 64-bit product {hi, lo}; operands are widened to 33 bits so a single
    // signed multiply serves both the signed and the unsigned variant.
    function automatic logic [63:0] mul_full(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic        sgn);
        logic signed [32:0] a33;
        logic signed [32:0] b33;
        logic signed [63:0] p64;
        a33 = sgn ? $signed({a[31], a}) : $signed({1'b0, a});
        b33 = sgn ? $signed({b[31], b}) : $signed({1'b0, b});
        p64 = a33 * b33;
        return p64;
    endfunction

    // {remainder, quotient}; truncating division with the remainder taking
    // the dividend's sign. The 33-bit width makes 0x80000000 / -1 yield
    // quotient 0x80000000 and remainder 0 without overflow. A zero divisor
    // returns zero; the caller never commits that result.
    function automatic logic [63:0] div_full(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic        sgn);
        logic signed [32:0] a33;
        logic signed [32:0] b33;
        logic signed [32:0] q33;
        logic signed [32:0] r33;
        a33 = sgn ? $signed({a[31], a}) : $signed({1'b0, a});
        b33 = sgn ? $signed({b[31], b}) : $signed({1'b0, b});
        if (b == 32'd0) begin
            q33 = 33'sd0;
            r33 = 33'sd0;
        end else begin
            q33 = a33 / b33;
            r33 = a33 % b33;
        end
        return {r33[31:0], q33[31:0]};
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// E-stage handshake between the pipeline and the multiply/divide unit.
interface mult_div_unit_if;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Flush;
    logic        MDUse;
    logic        Busy;
    logic        Stall;
    logic [31:0] HI;
    logic [31:0] LO;

    // Pipeline side: issues operations, observes status and HI/LO.
    modport master (
        output Start, MDOp, A, B, Flush, MDUse,
        input  Busy, Stall, HI, LO
    );

    // Unit side.
    modport slave (
        input  Start, MDOp, A, B, Flush, MDUse,
        output Busy, Stall, HI, LO
    );
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO. The result is computed at
// Start and parked in pending registers; the down-counter only models the
// latency before the pending value is committed to HI/LO.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic           clk,
    input  logic           reset,
    mult_div_unit_if.slave mdu
);

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    mdu_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        dz_q, dz_d;
    logic        busy_q, busy_d;
    logic [63:0] mul_res_s;
    logic [63:0] div_res_s;

    // Arithmetic on the forwarded operands, evaluated every cycle but only
    // captured when an operation is accepted.
    always_comb begin
        mul_res_s = mul_full(mdu.A, mdu.B, mdu.MDOp == MD_MULT);
        div_res_s = div_full(mdu.A, mdu.B, mdu.MDOp == MD_DIV);
    end

    // Next-state, counter, pending and HI/LO update logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        dz_d      = dz_q;
        case (state_q)
            ST_IDLE: begin
                // A same-cycle Flush cancels the instruction carrying Start.
                if (mdu.Start && !mdu.Flush) begin
                    case (mdu.MDOp)
                        MD_MULT, MD_MULTU: begin
                            pend_hi_d = mul_res_s[63:32];
                            pend_lo_d = mul_res_s[31:0];
                            dz_d      = 1'b0;
                            cnt_d     = MULT_CNT;
                            state_d   = ST_RUN;
                        end
                        MD_DIV, MD_DIVU: begin
                            // Divide-by-zero still takes the full latency,
                            // but HI/LO are left untouched at the end.
                            if (mdu.B == 32'd0) begin
                                dz_d = 1'b1;
                            end else begin
                                dz_d      = 1'b0;
                                pend_hi_d = div_res_s[63:32];
                                pend_lo_d = div_res_s[31:0];
                            end
                            cnt_d   = DIV_CNT;
                            state_d = ST_RUN;
                        end
                        MD_MTHI: hi_d = mdu.A;
                        MD_MTLO: lo_d = mdu.A;
                        default: state_d = ST_IDLE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Flush beats the final-cycle commit; new Starts are ignored.
                if (mdu.Flush) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                    dz_d    = 1'b0;
                end else if (cnt_q == 4'd1) begin
                    if (!dz_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end else begin
                        hi_d = hi_q;
                        lo_d = lo_q;
                    end
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                    dz_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        busy_d = (state_d == ST_RUN);
    end

    // State, counter, HI/LO and pending registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            dz_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            dz_q      <= dz_d;
            busy_q    <= busy_d;
        end
    end

    assign mdu.Busy  = busy_q;
    assign mdu.HI    = hi_q;
    assign mdu.LO    = lo_q;
    // The hazard unit needs the stall in the same cycle a long op issues.
    assign mdu.Stall = mdu.MDUse & (busy_q | (mdu.Start & is_long_op(mdu.MDOp)));

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed testbench for mult_div_unit with hand-computed expected values.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mult_div_unit_if mdu_if ();

    mult_div_unit #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .mdu  (mdu_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock edge; returns 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mdu_if.Start = 1'b0;
        mdu_if.MDOp  = MD_NONE;
        mdu_if.A     = 32'd0;
        mdu_if.B     = 32'd0;
        mdu_if.Flush = 1'b0;
        mdu_if.MDUse = 1'b0;
    endtask

    // Issue a long op, check Busy/Stall/HI/LO across its n Busy cycles and
    // the commit seen in the first non-busy cycle.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int n, input logic use_d,
                          input logic [31:0] ehi, input logic [31:0] elo);
        mdu_if.Start = 1'b1;
        mdu_if.MDOp  = op;
        mdu_if.A     = a;
        mdu_if.B     = b;
        mdu_if.MDUse = use_d;
        #1;
        check_val({tag, "_stall_issue"}, {31'd0, mdu_if.Stall}, {31'd0, use_d});
        step();
        idle_inputs();
        mdu_if.MDUse = use_d;
        for (int i = 0; i < n; i++) begin
            check_val($sformatf("%s_busy%0d", tag, i + 1), {31'd0, mdu_if.Busy}, 32'd1);
            check_val($sformatf("%s_stall%0d", tag, i + 1), {31'd0, mdu_if.Stall}, {31'd0, use_d});
            check_val($sformatf("%s_hi_hold%0d", tag, i + 1), mdu_if.HI, m_hi);
            check_val($sformatf("%s_lo_hold%0d", tag, i + 1), mdu_if.LO, m_lo);
            step();
        end
        check_val({tag, "_busy_done"}, {31'd0, mdu_if.Busy}, 32'd0);
        check_val({tag, "_stall_done"}, {31'd0, mdu_if.Stall}, 32'd0);
        check_val({tag, "_hi"}, mdu_if.HI, ehi);
        check_val({tag, "_lo"}, mdu_if.LO, elo);
        m_hi = ehi;
        m_lo = elo;
        mdu_if.MDUse = 1'b0;
    endtask

    task automatic move_to(input string tag, input logic [2:0] op,
                           input logic [31:0] a, input logic flush);
        mdu_if.Start = 1'b1;
        mdu_if.MDOp  = op;
        mdu_if.A     = a;
        mdu_if.Flush = flush;
        step();
        idle_inputs();
        if (!flush) begin
            if (op == MD_MTHI) m_hi = a;
            else if (op == MD_MTLO) m_lo = a;
            else m_hi = m_hi;
        end
        check_val({tag, "_busy"}, {31'd0, mdu_if.Busy}, 32'd0);
        check_val({tag, "_hi"}, mdu_if.HI, m_hi);
        check_val({tag, "_lo"}, mdu_if.LO, m_lo);
    endtask

    // Start a long op and advance to the k-th Busy cycle.
    task automatic start_and_wait(input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input int k);
        mdu_if.Start = 1'b1;
        mdu_if.MDOp  = op;
        mdu_if.A     = a;
        mdu_if.B     = b;
        step();
        idle_inputs();
        for (int i = 1; i < k; i++) step();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_hi    = 32'd0;
        m_lo    = 32'd0;
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        check_val("rst_busy", {31'd0, mdu_if.Busy}, 32'd0);
        check_val("rst_hi", mdu_if.HI, 32'd0);
        check_val("rst_lo", mdu_if.LO, 32'd0);
        check_val("rst_stall", {31'd0, mdu_if.Stall}, 32'd0);

        // Signed and unsigned products of -2 * 3, issued back to back.
        run_op("mult", MD_MULT, 32'hFFFF_FFFE, 32'd3, 5, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu", MD_MULTU, 32'hFFFF_FFFE, 32'd3, 5, 1'b0, 32'h0000_0002, 32'hFFFF_FFFA);

        // -7 / 2 = -3 remainder -1.
        run_op("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        // Divide by zero leaves HI/LO alone but keeps the full latency.
        move_to("mthi", MD_MTHI, 32'h0000_1234, 1'b0);
        move_to("mtlo", MD_MTLO, 32'h0000_1234, 1'b0);
        run_op("div0", MD_DIV, 32'd5, 32'd0, 10, 1'b0, 32'h0000_1234, 32'h0000_1234);

        // Overflow case and an unsigned divide.
        run_op("divovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0, 32'h0000_0000, 32'h8000_0000);
        run_op("divu", MD_DIVU, 32'hFFFF_FFFF, 32'd16, 10, 1'b0, 32'h0000_000F, 32'h0FFF_FFFF);

        // Flush in the third Busy cycle.
        start_and_wait(MD_MULT, 32'd7, 32'd9, 3);
        mdu_if.Flush = 1'b1;
        step();
        idle_inputs();
        check_val("flush3_busy", {31'd0, mdu_if.Busy}, 32'd0);
        check_val("flush3_hi", mdu_if.HI, m_hi);
        check_val("flush3_lo", mdu_if.LO, m_lo);
        for (int i = 0; i < 6; i++) step();
        check_val("flush3_lo_late", mdu_if.LO, m_lo);

        // Flush coinciding with the final Busy cycle.
        start_and_wait(MD_MULT, 32'd7, 32'd9, 5);
        check_val("flushlast_busy_pre", {31'd0, mdu_if.Busy}, 32'd1);
        mdu_if.Flush = 1'b1;
        step();
        idle_inputs();
        check_val("flushlast_busy", {31'd0, mdu_if.Busy}, 32'd0);
        check_val("flushlast_hi", mdu_if.HI, m_hi);
        check_val("flushlast_lo", mdu_if.LO, m_lo);

        // mtlo with no Busy; Flush in IDLE gates mthi and a mult; NONE no-op.
        move_to("mtlo_dead", MD_MTLO, 32'hDEAD_BEEF, 1'b0);
        step();
        check_val("mtlo_dead_busy2", {31'd0, mdu_if.Busy}, 32'd0);
        move_to("mthi_flushed", MD_MTHI, 32'h5555_AAAA, 1'b1);
        move_to("mult_flushed", MD_MULT, 32'd3, 1'b1);
        move_to("none", MD_NONE, 32'h7777_7777, 1'b0);

        // Stall: only MDUse with a busy/issuing long op; not for mthi.
        mdu_if.MDUse = 1'b1;
        mdu_if.Start = 1'b1;
        mdu_if.MDOp  = MD_MTHI;
        #1;
        check_val("stall_mthi", {31'd0, mdu_if.Stall}, 32'd0);
        idle_inputs();
        mdu_if.MDUse = 1'b1;
        #1;
        check_val("stall_idle", {31'd0, mdu_if.Stall}, 32'd0);
        idle_inputs();

        // Start during RUN is ignored; the original 6*7 result commits.
        start_and_wait(MD_MULT, 32'd6, 32'd7, 2);
        mdu_if.Start = 1'b1;
        mdu_if.MDOp  = MD_DIV;
        mdu_if.A     = 32'd100;
        mdu_if.B     = 32'd3;
        step();
        idle_inputs();
        check_val("ign_busy3", {31'd0, mdu_if.Busy}, 32'd1);
        step();
        step();
        check_val("ign_busy5", {31'd0, mdu_if.Busy}, 32'd1);
        step();
        m_hi = 32'd0;
        m_lo = 32'd42;
        check_val("ign_busy_done", {31'd0, mdu_if.Busy}, 32'd0);
        check_val("ign_hi", mdu_if.HI, m_hi);
        check_val("ign_lo", mdu_if.LO, m_lo);
        step();
        check_val("ign_busy_after", {31'd0, mdu_if.Busy}, 32'd0);

        // Reset in Busy cycle 7 of a divide (counter at 4).
        start_and_wait(MD_DIVU, 32'd100, 32'd7, 7);
        check_val("rstrun_busy_pre", {31'd0, mdu_if.Busy}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        check_val("rstrun_busy", {31'd0, mdu_if.Busy}, 32'd0);
        check_val("rstrun_hi", mdu_if.HI, 32'd0);
        check_val("rstrun_lo", mdu_if.LO, 32'd0);
        for (int i = 0; i < 4; i++) step();
        check_val("rstrun_lo_late", mdu_if.LO, 32'd0);

        // Unit is usable again after reset.
        run_op("post_rst", MD_DIVU, 32'd100, 32'd7, 10, 1'b1, 32'd2, 32'd14);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
